register_mode_fifo: RTL and testbench
=====================================

Name: register_mode_fifo

Overview:
- Parametrised successor to the single-register mode cell used in CGRA tile I/O and PE operand paths.
- Each cycle it presents a constant, a bypassed input, a held register value, or the head of a DEPTH-entry FIFO.
- Valid/ready handshakes on both input and output sides.
- Config port writes the head entry (register value) directly.

Parameters:
- WIDTH, 16, data width of value, const_, config_data, O0, O1
- DEPTH, 4, FIFO entries; power of two, >= 2; PTR_W = log2(DEPTH)

Ports:
- CLK  in  1  sole clock, rising edge
- ASYNCRESETN  in  1  asynchronous, active-low reset
- mode  in  2  0=CONST, 1=BYPASS, 2=DELAY, 3=FIFO
- const_  in  WIDTH  constant output for CONST
- value  in  WIDTH  input data
- value_valid  in  1  input valid
- value_ready  out  1  input ready
- O0  out  WIDTH  output data
- out_valid  out  1  output valid
- out_ready  in  1  downstream ready
- clk_en  in  1  stall when 0, for DELAY/FIFO
- config_we  in  1  config write strobe
- config_data  in  WIDTH  config write data
- O1  out  WIDTH  read-back of head entry mem[rd_ptr]
- count  out  PTR_W+1  FIFO occupancy

Behaviour:
- State:
  - mem[DEPTH] x WIDTH
  - rd_ptr, wr_ptr: PTR_W bits each; wrap modulo DEPTH
  - count: PTR_W+1 bits
- Reset (ASYNCRESETN=0, immediate): mem all 0, pointers 0, count 0.
  - O1=0, count=0.
  - O0/out_valid/value_ready follow the mode rules below, with empty storage.
- config_we=1 has top priority in every mode:
  - mem[rd_ptr] <= config_data at the edge.
  - value_ready=0 and out_valid=0 combinationally.
  - No push/pop; pointers and count unchanged.
- CONST:
  - O0=const_, out_valid=1, value_ready=1 (input discarded).
  - State held.
- BYPASS (purely combinational, zero latency):
  - O0=value, out_valid=value_valid, value_ready=out_ready.
  - State held.
- DELAY:
  - O0=mem[rd_ptr], out_valid=1, value_ready=clk_en.
  - On clk_en & value_valid: mem[rd_ptr] <= value. Visible on O0 one cycle later.
  - Pointers and count held.
- FIFO:
  - value_ready = clk_en & (count != DEPTH).
  - out_valid = clk_en & (count != 0).
  - O0 = mem[rd_ptr].
  - push = value_valid & value_ready: mem[wr_ptr] <= value, wr_ptr+1.
  - pop = out_valid & out_ready: rd_ptr+1.
  - count += push - pop. Simultaneous push and pop leaves count unchanged.
  - Full: no push, even if a pop happens the same cycle (no pass-through).
  - Empty: out_valid=0. A pushed word appears on O0 the next cycle (1-cycle latency, no fall-through).
- Mode changes take effect combinationally.
  - Pointers and count are held outside FIFO mode.
  - Re-entering FIFO resumes with prior contents.
- O1 always equals mem[rd_ptr], in every mode.
- count is never > DEPTH. Pointer wrap DEPTH-1 -> 0 is silent.

Decomposition:
- Shared package register_mode_pkg:
  - MODE_CONST, MODE_BYPASS, MODE_DELAY, MODE_FIFO as 2-bit constants
  - mode_t typedef
- One sub-module, register_mode_storage:
  - Owns mem, pointers, count.
  - Write-port mux: config / delay / push.
  - Read port at rd_ptr.
  - Top level holds only the mode-select output muxes and handshake logic.

Test Plan:
- Reset then CONST, const_=0x00A5 -> O0=0x00A5, out_valid=1, value_ready=1, count=0, O1=0.
- BYPASS, value=0x1234, value_valid=1, out_ready=0 -> O0=0x1234 same cycle, out_valid=1, value_ready=0.
- DELAY, clk_en=1, push 0x0011 then 0x0022 -> O0 = 0x0000, 0x0011, 0x0022 on consecutive cycles. With clk_en=0, O0 stays 0x0022.
- FIFO, DEPTH=4, push 1,2,3,4 with out_ready=0 -> count=4, value_ready=0. A 5th value is refused. Then out_ready=1 pops 1,2,3,4 in order, and count returns to 0.
- FIFO at count=2, simultaneous push/pop for 8 cycles -> count stays 2, FIFO order preserved across pointer wrap.
- FIFO holding 3 entries, config_we=1 with 0xBEEF -> O1=0xBEEF next cycle, count=3. Mid-stream ASYNCRESETN low -> count=0 and O1=0 immediately.

Source files
------------

// File: rtl/register_mode_pkg.sv
// Shared mode encoding for the register-mode cell and its storage.
package register_mode_pkg;

  typedef enum logic [1:0] {
    MODE_CONST  = 2'd0,
    MODE_BYPASS = 2'd1,
    MODE_DELAY  = 2'd2,
    MODE_FIFO   = 2'd3
  } mode_t;

endpackage

// File: rtl/register_mode_storage.sv
// Storage for register_mode_fifo: DEPTH-entry memory, read/write pointers and occupancy.
// One write port muxed between config, delay-register update and FIFO push.
module register_mode_storage #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             delay_we,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rd_data,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             we;
  logic [PTR_W-1:0] waddr;
  logic [WIDTH-1:0] wval;

  // Config and delay both target the head entry; config wins.
  always_comb begin
    we    = 1'b0;
    waddr = rd_ptr_q;
    wval  = wdata;
    if (cfg_we) begin
      we   = 1'b1;
      wval = cfg_data;
    end else if (delay_we) begin
      we = 1'b1;
    end else if (push) begin
      we    = 1'b1;
      waddr = wr_ptr_q;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (we) mem_q[waddr] <= wval;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/register_mode_fifo.sv
// Mode-selectable operand cell: constant, bypass, delay register or DEPTH-entry FIFO,
// with valid/ready on both sides and a config port that overwrites the head entry.
module register_mode_fifo
  import register_mode_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] const_,
  input  logic [WIDTH-1:0] value,
  input  logic             value_valid,
  output logic             value_ready,
  output logic [WIDTH-1:0] O0,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clk_en,
  input  logic             config_we,
  input  logic [WIDTH-1:0] config_data,
  output logic [WIDTH-1:0] O1,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] head;
  logic             push;
  logic             pop;
  logic             delay_we;

  register_mode_storage #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_storage (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .cfg_we      (config_we),
    .cfg_data    (config_data),
    .delay_we    (delay_we),
    .push        (push),
    .pop         (pop),
    .wdata       (value),
    .rd_data     (head),
    .count       (count)
  );

  always_comb begin
    O0          = head;
    out_valid   = 1'b0;
    value_ready = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    delay_we    = 1'b0;
    unique case (mode_t'(mode))
      MODE_CONST: begin
        O0          = const_;
        out_valid   = 1'b1;
        value_ready = 1'b1;
      end
      MODE_BYPASS: begin
        O0          = value;
        out_valid   = value_valid;
        value_ready = out_ready;
      end
      MODE_DELAY: begin
        out_valid   = 1'b1;
        value_ready = clk_en;
        delay_we    = clk_en & value_valid;
      end
      MODE_FIFO: begin
        // Full blocks push even when a pop happens the same cycle.
        value_ready = clk_en & (count != FullCount);
        out_valid   = clk_en & (count != '0);
        push        = value_valid & value_ready;
        pop         = out_valid & out_ready;
      end
    endcase
    // A config write freezes both handshakes and all storage movement.
    if (config_we) begin
      value_ready = 1'b0;
      out_valid   = 1'b0;
      push        = 1'b0;
      pop         = 1'b0;
      delay_we    = 1'b0;
    end
  end

  assign O1 = head;

endmodule

// File: tb/tb_register_mode_fifo.sv
// Directed self-checking bench for register_mode_fifo (WIDTH=16, DEPTH=4).
module tb_register_mode_fifo;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;

  logic             CLK = 1'b0;
  logic             ASYNCRESETN;
  logic [1:0]       mode;
  logic [WIDTH-1:0] const_;
  logic [WIDTH-1:0] value;
  logic             value_valid;
  logic             value_ready;
  logic [WIDTH-1:0] O0;
  logic             out_valid;
  logic             out_ready;
  logic             clk_en;
  logic             config_we;
  logic [WIDTH-1:0] config_data;
  logic [WIDTH-1:0] O1;
  logic [PTR_W:0]   count;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [WIDTH-1:0] exp_q[$];

  register_mode_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) dut (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .mode        (mode),
    .const_      (const_),
    .value       (value),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .O0          (O0),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .clk_en      (clk_en),
    .config_we   (config_we),
    .config_data (config_data),
    .O1          (O1),
    .count       (count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    ASYNCRESETN = 1'b0;
    mode        = 2'd0;
    const_      = 16'h00A5;
    value       = '0;
    value_valid = 1'b0;
    out_ready   = 1'b0;
    clk_en      = 1'b0;
    config_we   = 1'b0;
    config_data = '0;
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_o1", 32'(O1), 0);
    #1 ASYNCRESETN = 1'b1;
    tick();

    // CONST
    check("const_o0", 32'(O0), 32'h00A5);
    check("const_ov", 32'(out_valid), 1);
    check("const_vr", 32'(value_ready), 1);
    check("const_count", 32'(count), 0);
    check("const_o1", 32'(O1), 0);

    // BYPASS
    mode = 2'd1; value = 16'h1234; value_valid = 1'b1; out_ready = 1'b0;
    #1;
    check("byp_o0", 32'(O0), 32'h1234);
    check("byp_ov", 32'(out_valid), 1);
    check("byp_vr0", 32'(value_ready), 0);
    out_ready = 1'b1;
    #1;
    check("byp_vr1", 32'(value_ready), 1);

    // DELAY
    mode = 2'd2; clk_en = 1'b1; value = 16'h0011; value_valid = 1'b1; out_ready = 1'b0;
    #1;
    check("dly_o0_0", 32'(O0), 32'h0000);
    check("dly_ov", 32'(out_valid), 1);
    tick();
    check("dly_o0_1", 32'(O0), 32'h0011);
    value = 16'h0022;
    tick();
    check("dly_o0_2", 32'(O0), 32'h0022);
    clk_en = 1'b0; value = 16'h0033;
    #1;
    check("dly_vr_stall", 32'(value_ready), 0);
    tick();
    check("dly_o0_hold", 32'(O0), 32'h0022);
    check("dly_o1", 32'(O1), 32'h0022);
    check("dly_count", 32'(count), 0);

    // FIFO fill
    mode = 2'd3; clk_en = 1'b1; value_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("fifo_empty_ov", 32'(out_valid), 0);
    check("fifo_empty_vr", 32'(value_ready), 1);
    value_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      value = 16'(i);
      tick();
    end
    check("fifo_full_count", 32'(count), 4);
    check("fifo_full_vr", 32'(value_ready), 0);
    value = 16'h0005;
    out_ready = 1'b1;
    #1;
    check("fifo_full_pop_vr", 32'(value_ready), 0);
    value_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("fifo_pop%0d_o0", i), 32'(O0), 32'(i));
      check($sformatf("fifo_pop%0d_ov", i), 32'(out_valid), 1);
      tick();
    end
    check("fifo_drained_count", 32'(count), 0);
    check("fifo_drained_ov", 32'(out_valid), 0);

    // Steady state at count=2 across pointer wrap
    out_ready = 1'b0; value_valid = 1'b1;
    value = 16'h000A; exp_q.push_back(value); tick();
    check("fifo_nofall_o0", 32'(O0), 32'h000A);
    value = 16'h000B; exp_q.push_back(value); tick();
    check("fifo_two_count", 32'(count), 2);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      value = 16'h0C00 + 16'(i);
      #1;
      check($sformatf("fifo_ss%0d_o0", i), 32'(O0), 32'(exp_q[0]));
      void'(exp_q.pop_front());
      exp_q.push_back(value);
      tick();
      check($sformatf("fifo_ss%0d_count", i), 32'(count), 2);
    end

    // Third entry, then config overwrite of head
    out_ready = 1'b0; value = 16'h0077; tick();
    check("fifo_three_count", 32'(count), 3);
    config_we = 1'b1; config_data = 16'hBEEF; value_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("cfg_vr", 32'(value_ready), 0);
    check("cfg_ov", 32'(out_valid), 0);
    tick();
    config_we = 1'b0; value_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("cfg_o1", 32'(O1), 32'hBEEF);
    check("cfg_o0", 32'(O0), 32'hBEEF);
    check("cfg_count", 32'(count), 3);

    // Mid-stream asynchronous reset
    #2 ASYNCRESETN = 1'b0;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_o1", 32'(O1), 0);
    check("arst_ov", 32'(out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
